// File: rtl/gray_pkg.sv
// Shared definitions for the gray counter monitor slice.
package gray_pkg;

    localparam int GRAY_W    = 3;
    localparam int ERR_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary decoder of arbitrary width.
module gray2bin #(
    parameter int W = 3
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        logic acc;
        acc   = 1'b0;
        bin_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// File: rtl/gray_monitor.sv
// Legality monitor for the upstream 3-bit gray counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | no reference yet; next Valid captures one
//   ST_TRACK | checking each Valid sample against the reference
//   ST_FAULT | error limit reached; everything frozen until Clear
module gray_monitor
    import gray_pkg::*;
#(
    parameter int WRAP_W    = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Valid,
    input  logic [GRAY_W-1:0]        GrayIn,
    input  logic                     OverflowIn,
    input  logic                     Clear,
    output logic [GRAY_W-1:0]        BinOut,
    output logic [WRAP_W+GRAY_W-1:0] Count,
    output logic                     WrapPulse,
    output logic                     ErrPulse,
    output logic [ERR_CNT_W-1:0]     ErrCnt,
    output logic                     Fault
);

    localparam logic [ERR_CNT_W-1:0] ERR_LIMIT_C = ERR_CNT_W'(ERR_LIMIT);
    localparam logic [ERR_CNT_W-1:0] ERR_SAT     = '1;
    localparam logic [GRAY_W-1:0]    BIN_MAX     = '1;

    state_t                 state_q, state_d;
    logic [GRAY_W-1:0]      bin_q, bin_d;
    logic [WRAP_W-1:0]      wrap_q, wrap_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   wrap_pulse_q, wrap_pulse_d;
    logic                   err_pulse_q, err_pulse_d;

    logic [GRAY_W-1:0]      gray_bin;
    logic [GRAY_W-1:0]      bin_inc;
    logic [ERR_CNT_W-1:0]   err_cnt_inc;

    gray2bin #(.W(GRAY_W)) u_gray2bin (
        .gray_i (GrayIn),
        .bin_o  (gray_bin)
    );

    assign bin_inc     = bin_q + GRAY_W'(1);
    assign err_cnt_inc = (err_cnt_q == ERR_SAT) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);

    // Next-state: capture, classify each transition, count errors, freeze on fault.
    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        wrap_d       = wrap_q;
        err_cnt_d    = err_cnt_q;
        wrap_pulse_d = 1'b0;
        err_pulse_d  = 1'b0;
        if (Clear) begin
            state_d   = ST_IDLE;
            bin_d     = '0;
            wrap_d    = '0;
            err_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Valid) begin
                        bin_d   = gray_bin;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    // A repeated code is a hold and is never judged.
                    if (Valid && (gray_bin != bin_q)) begin
                        if ((bin_q != BIN_MAX) && (gray_bin == bin_inc) && !OverflowIn) begin
                            bin_d = gray_bin;
                        end else if ((bin_q == BIN_MAX) && (gray_bin == '0) && OverflowIn) begin
                            bin_d        = '0;
                            wrap_d       = wrap_q + WRAP_W'(1);
                            wrap_pulse_d = 1'b1;
                        end else begin
                            // Resync to whatever arrived so one glitch costs one error.
                            bin_d       = gray_bin;
                            err_pulse_d = 1'b1;
                            err_cnt_d   = err_cnt_inc;
                            if (err_cnt_inc >= ERR_LIMIT_C) begin
                                state_d = ST_FAULT;
                            end
                        end
                    end
                end
                ST_FAULT: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            bin_q        <= '0;
            wrap_q       <= '0;
            err_cnt_q    <= '0;
            wrap_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            wrap_q       <= wrap_d;
            err_cnt_q    <= err_cnt_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign BinOut    = bin_q;
    assign Count     = {wrap_q, bin_q};
    assign WrapPulse = wrap_pulse_q;
    assign ErrPulse  = err_pulse_q;
    assign ErrCnt    = err_cnt_q;
    assign Fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor (WRAP_W=2 so wrap rollover is reachable).
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Valid = 1'b0;
    logic [2:0] GrayIn = 3'b000;
    logic       OverflowIn = 1'b0;
    logic       Clear = 1'b0;
    logic [2:0] BinOut;
    logic [4:0] Count;
    logic       WrapPulse;
    logic       ErrPulse;
    logic [3:0] ErrCnt;
    logic       Fault;

    int errors = 0;
    int checks = 0;
    int step_id = 0;

    typedef struct {
        int         id;
        logic [2:0] bin;
        logic [4:0] cnt;
        logic       wp;
        logic       ep;
        logic [3:0] ec;
        logic       f;
    } exp_t;

    exp_t exp_q[$];
    logic [2:0] gray_of [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    gray_monitor #(.WRAP_W(2), .ERR_LIMIT(3)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Valid      (Valid),
        .GrayIn     (GrayIn),
        .OverflowIn (OverflowIn),
        .Clear      (Clear),
        .BinOut     (BinOut),
        .Count      (Count),
        .WrapPulse  (WrapPulse),
        .ErrPulse   (ErrPulse),
        .ErrCnt     (ErrCnt),
        .Fault      (Fault)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step%0d %s: got %0h expected %0h", id, name, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("BinOut", e.id, 32'(BinOut), 32'(e.bin));
        chk("Count", e.id, 32'(Count), 32'(e.cnt));
        chk("WrapPulse", e.id, 32'(WrapPulse), 32'(e.wp));
        chk("ErrPulse", e.id, 32'(ErrPulse), 32'(e.ep));
        chk("ErrCnt", e.id, 32'(ErrCnt), 32'(e.ec));
        chk("Fault", e.id, 32'(Fault), 32'(e.f));
    endtask

    // Drive one cycle of stimulus and queue the response expected after the next edge.
    task automatic d(input logic v, input logic [2:0] g, input logic ov, input logic clr,
                     input logic [2:0] eb, input logic [4:0] ecnt, input logic ewp,
                     input logic eep, input logic [3:0] eec, input logic ef);
        exp_t e;
        @(negedge Clk);
        Valid = v; GrayIn = g; OverflowIn = ov; Clear = clr;
        step_id++;
        e.id = step_id; e.bin = eb; e.cnt = ecnt; e.wp = ewp; e.ep = eep; e.ec = eec; e.f = ef;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation after each edge.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk_all(e);
        end
    end

    initial begin
        exp_t z;
        z.id = 0; z.bin = 0; z.cnt = 0; z.wp = 0; z.ep = 0; z.ec = 0; z.f = 0;
        repeat (3) @(posedge Clk);
        #1 chk_all(z);
        @(negedge Clk) Reset = 1'b1;

        // Normal counting through one wrap.
        d(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        d(1, 3'b001, 0, 0, 1, 1, 0, 0, 0, 0);
        d(1, 3'b011, 0, 0, 2, 2, 0, 0, 0, 0);
        d(1, 3'b010, 0, 0, 3, 3, 0, 0, 0, 0);
        d(1, 3'b110, 0, 0, 4, 4, 0, 0, 0, 0);
        d(1, 3'b111, 0, 0, 5, 5, 0, 0, 0, 0);
        d(1, 3'b101, 0, 0, 6, 6, 0, 0, 0, 0);
        d(1, 3'b100, 0, 0, 7, 7, 0, 0, 0, 0);
        d(1, 3'b000, 1, 0, 0, 8, 1, 0, 0, 0);
        d(1, 3'b001, 0, 0, 1, 9, 0, 0, 0, 0);
        // Holds and Valid low.
        d(1, 3'b011, 0, 0, 2, 10, 0, 0, 0, 0);
        d(1, 3'b011, 1, 0, 2, 10, 0, 0, 0, 0);
        d(1, 3'b011, 0, 0, 2, 10, 0, 0, 0, 0);
        d(1, 3'b011, 0, 0, 2, 10, 0, 0, 0, 0);
        d(0, 3'b111, 0, 0, 2, 10, 0, 0, 0, 0);
        // Overflow mismatches: 7->0 without overflow, 2->3 with overflow.
        d(1, 3'b010, 0, 0, 3, 11, 0, 0, 0, 0);
        d(1, 3'b110, 0, 0, 4, 12, 0, 0, 0, 0);
        d(1, 3'b111, 0, 0, 5, 13, 0, 0, 0, 0);
        d(1, 3'b101, 0, 0, 6, 14, 0, 0, 0, 0);
        d(1, 3'b100, 0, 0, 7, 15, 0, 0, 0, 0);
        d(1, 3'b000, 0, 0, 0, 8, 0, 1, 1, 0);
        d(1, 3'b001, 0, 0, 1, 9, 0, 0, 1, 0);
        d(1, 3'b011, 0, 0, 2, 10, 0, 0, 1, 0);
        d(1, 3'b010, 1, 0, 3, 11, 0, 1, 2, 0);
        d(0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0);
        // Illegal jump 1->4 then legal 4->5.
        d(1, 3'b001, 0, 0, 1, 1, 0, 0, 0, 0);
        d(1, 3'b110, 0, 0, 4, 4, 0, 1, 1, 0);
        d(1, 3'b111, 0, 0, 5, 5, 0, 0, 1, 0);
        d(0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0);
        // Three illegal jumps reach FAULT; frozen; Clear beats Valid.
        d(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        d(1, 3'b011, 0, 0, 2, 2, 0, 1, 1, 0);
        d(1, 3'b111, 0, 0, 5, 5, 0, 1, 2, 0);
        d(1, 3'b001, 0, 0, 1, 1, 0, 1, 3, 1);
        d(1, 3'b011, 0, 0, 1, 1, 0, 0, 3, 1);
        d(1, 3'b010, 1, 0, 1, 1, 0, 0, 3, 1);
        d(1, 3'b110, 0, 1, 0, 0, 0, 0, 0, 0);
        d(1, 3'b110, 0, 0, 4, 4, 0, 0, 0, 0);
        d(0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0);
        // Four full cycles: 2-bit wrap counter rolls back to 0.
        d(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            for (int i = 1; i <= 8; i++) begin
                logic [2:0] b;
                logic [1:0] w;
                b = 3'(i % 8);
                w = 2'(c + ((i == 8) ? 1 : 0));
                d(1, gray_of[b], (i == 8), 0, b, {w, b}, (i == 8), 0, 0, 0);
            end
        end
        d(1, 3'b001, 0, 0, 1, 1, 0, 0, 0, 0);
        d(1, 3'b011, 0, 0, 2, 2, 0, 0, 0, 0);
        d(1, 3'b110, 0, 0, 4, 4, 0, 1, 1, 0);
        d(0, 3'b000, 0, 0, 4, 4, 0, 0, 1, 0);
        // Async reset mid-cycle: outputs drop without a clock edge.
        @(posedge Clk);
        #3 Reset = 1'b0;
        #1 chk_all(z);
        @(negedge Clk) Reset = 1'b1;
        d(1, 3'b011, 0, 0, 2, 2, 0, 0, 0, 0);
        d(1, 3'b010, 0, 0, 3, 3, 0, 0, 0, 0);
        d(0, 3'b000, 0, 0, 3, 3, 0, 0, 0, 0);
        repeat (3) @(posedge Clk);
        #2 chk("queue_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_monitor.md
# gray_monitor

- Downstream consumer of the 3-bit gray counter stage: samples its `Output`/`Overflow` pair whenever the counter is enabled.
- Decodes gray to binary and extends the count with a wrap counter.
- Checks every transition for legality (single-step, +1 direction, overflow coherence).
- Latches a fault after repeated violations, so upstream counter health is observable in one register.

## Interface

Parameters:
- `WRAP_W`, default 8: width of the wrap counter. Extended count width is `WRAP_W+3`.
- `ERR_LIMIT`, default 3: number of illegal transitions that forces FAULT. Legal range 1..15.

Ports:
- `Clk`, input, 1: single clock; all state updates on the rising edge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `Valid`, input, 1: sample strobe, driven by the same signal as the upstream `En`.
- `GrayIn`, input, 3: upstream gray code.
- `OverflowIn`, input, 1: upstream overflow flag.
- `Clear`, input, 1: synchronous clear of all state; returns the block to IDLE.
- `BinOut`, output, 3: binary value of the last accepted sample.
- `Count`, output, WRAP_W+3: `{wrap_count, BinOut}`.
- `WrapPulse`, output, 1: one-cycle pulse on each accepted 7->0 step.
- `ErrPulse`, output, 1: one-cycle pulse on each illegal transition.
- `ErrCnt`, output, 4: saturating count of illegal transitions.
- `Fault`, output, 1: high while in FAULT.

## Operation

- Gray to binary: `b2 = g2`, `b1 = g2^g1`, `b0 = g2^g1^g0`.
- FSM states: IDLE, TRACK, FAULT.
- IDLE:
  - On `Valid`, capture `GrayIn` as the reference and set `BinOut` to its binary value.
  - `OverflowIn` is ignored on this first sample. Wrap counter stays 0.
  - Go to TRACK.
- TRACK: on each `Valid`, let `p` be the previous binary value and `n` the new one.
  - `n == p`: hold. No update, no error. `OverflowIn` is don't-care.
  - `n == p+1`, with `p != 7`: legal step. Requires `OverflowIn == 0`.
  - `p == 7`, `n == 0`: legal wrap. Requires `OverflowIn == 1`. Increment the wrap counter modulo 2^WRAP_W (rollover is silent) and pulse `WrapPulse`.
  - Any other `n`, or an overflow mismatch on a step, is illegal:
    - pulse `ErrPulse` and increment `ErrCnt`, saturating at 15;
    - resynchronise the reference to `n` anyway;
    - do not touch the wrap counter.
  - If the incremented `ErrCnt` is >= `ERR_LIMIT`, go to FAULT.
- FAULT:
  - All registers frozen; `Valid` is ignored; `Fault` = 1.
  - Only `Clear` or `Reset` leaves FAULT.
- `Clear`:
  - Has priority over `Valid` in the same cycle.
  - Zeros `BinOut`, the wrap counter, `ErrCnt` and both pulses, then enters IDLE.
- Reset values: every output 0; state IDLE.

## Timing

- All outputs are registered. A sample taken on edge k is visible after edge k.
- Latency is one cycle from `Valid` to `BinOut`/`Count`/pulses.
- Back-to-back `Valid` on consecutive cycles is fully supported: one sample is processed per cycle with no stalls.
- Pulses are exactly one cycle wide and deassert on the next edge unless re-triggered.
- Reset asserted mid-operation clears everything asynchronously. The first `Valid` after release is treated as an IDLE capture.
- `Valid` low: all registers hold, pulses drop to 0.

## Structure

Shared package `gray_pkg`:
- `GRAY_W = 3`
- the `state_t` enum (IDLE/TRACK/FAULT)
- constant `ERR_CNT_W = 4`

Sub-module `gray2bin`:
- purely combinational, parameterised on width;
- instantiated once for `GrayIn`;
- reusable elsewhere in the design.

FSM, reference register, wrap counter and error counter live in `gray_monitor`.

## Test plan

1. **Normal counting.** Reset, then 10 `Valid` samples following the legal gray sequence from 000, with `OverflowIn` = 1 only on the 100->000 step.
   - `BinOut` steps 0..7, 0, 1.
   - `WrapPulse` fires once; `Count` = 9.
   - `ErrCnt` = 0.
2. **Hold samples.** Repeat gray 011 three times in TRACK.
   - `BinOut` = 2 throughout; no pulses.
3. **Illegal jump.** In TRACK at gray 001, apply gray 110 (binary 4).
   - `ErrPulse` for one cycle; `ErrCnt` = 1; `BinOut` = 4.
   - The next legal step, 4->5, is accepted.
4. **Overflow mismatch.**
   - Step 7->0 with `OverflowIn` = 0 gives `ErrPulse` and no `WrapPulse`; the wrap counter is unchanged.
   - A 2->3 step with `OverflowIn` = 1 also gives `ErrPulse`.
5. **Fault entry and clear.** With `ERR_LIMIT` = 3, inject three illegal jumps.
   - `Fault` = 1 after the third; further `Valid` samples change nothing.
   - `Clear` together with `Valid` gives all zeros and IDLE.
6. **Wrap rollover and async reset.** With `WRAP_W` = 2, run 4 full cycles.
   - The wrap counter returns to 0.
   - Assert `Reset` low mid-sequence: outputs are 0 immediately, without waiting for a clock edge.
